// File: rtl/zap_wb_arbiter.sv
// Two-master Wishbone B3 arbiter: whole-cycle grants, round-robin on contention,
// plus a sticky timeout flag for a slave that never acknowledges.
module zap_wb_arbiter #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TIE_FIRST      = 1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_m0_wb_cyc,
   input  logic        i_m0_wb_stb,
   input  logic        i_m0_wb_wen,
   input  logic [3:0]  i_m0_wb_sel,
   input  logic [31:0] i_m0_wb_dat,
   input  logic [31:0] i_m0_wb_adr,
   input  logic [2:0]  i_m0_wb_cti,
   output logic [31:0] o_m0_wb_dat,
   output logic        o_m0_wb_ack,
   input  logic        i_m1_wb_cyc,
   input  logic        i_m1_wb_stb,
   input  logic        i_m1_wb_wen,
   input  logic [3:0]  i_m1_wb_sel,
   input  logic [31:0] i_m1_wb_dat,
   input  logic [31:0] i_m1_wb_adr,
   input  logic [2:0]  i_m1_wb_cti,
   output logic [31:0] o_m1_wb_dat,
   output logic        o_m1_wb_ack,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_wen,
   output logic [3:0]  o_wb_sel,
   output logic [31:0] o_wb_dat,
   output logic [31:0] o_wb_adr,
   output logic [2:0]  o_wb_cti,
   input  logic [31:0] i_wb_dat,
   input  logic        i_wb_ack,
   output logic [1:0]  o_gnt,
   output logic        o_timeout
);

   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] SET_AT = CW'(TIMEOUT_CYCLES - 2);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   state_t        state_ff, state_nxt;
   logic          last_ff;
   logic [CW-1:0] cnt_ff;
   logic          stall;

   always_comb begin
      state_nxt = state_ff;
      case (state_ff)
         IDLE: begin
            if (i_m0_wb_cyc && i_m1_wb_cyc) state_nxt = last_ff ? GNT0 : GNT1;
            else if (i_m0_wb_cyc)           state_nxt = GNT0;
            else if (i_m1_wb_cyc)           state_nxt = GNT1;
         end
         GNT0:    if (!i_m0_wb_cyc) state_nxt = i_m1_wb_cyc ? GNT1 : IDLE;
         GNT1:    if (!i_m1_wb_cyc) state_nxt = i_m0_wb_cyc ? GNT0 : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_ff <= IDLE;
         last_ff  <= (TIE_FIRST == 0);
      end else begin
         state_ff <= state_nxt;
         if (state_nxt == GNT0 && state_ff != GNT0) last_ff <= 1'b0;
         if (state_nxt == GNT1 && state_ff != GNT1) last_ff <= 1'b1;
      end
   end

   always_comb begin
      o_wb_cyc = 1'b0;
      o_wb_stb = 1'b0;
      o_wb_wen = 1'b0;
      o_wb_sel = '0;
      o_wb_dat = '0;
      o_wb_adr = '0;
      o_wb_cti = '0;
      case (state_ff)
         GNT0: begin
            o_wb_cyc = i_m0_wb_cyc;
            o_wb_stb = i_m0_wb_stb;
            o_wb_wen = i_m0_wb_wen;
            o_wb_sel = i_m0_wb_sel;
            o_wb_dat = i_m0_wb_dat;
            o_wb_adr = i_m0_wb_adr;
            o_wb_cti = i_m0_wb_cti;
         end
         GNT1: begin
            o_wb_cyc = i_m1_wb_cyc;
            o_wb_stb = i_m1_wb_stb;
            o_wb_wen = i_m1_wb_wen;
            o_wb_sel = i_m1_wb_sel;
            o_wb_dat = i_m1_wb_dat;
            o_wb_adr = i_m1_wb_adr;
            o_wb_cti = i_m1_wb_cti;
         end
         default: ;
      endcase
   end

   assign o_m0_wb_ack = i_wb_ack & (state_ff == GNT0);
   assign o_m1_wb_ack = i_wb_ack & (state_ff == GNT1);
   assign o_m0_wb_dat = i_wb_dat;
   assign o_m1_wb_dat = i_wb_dat;
   assign o_gnt       = {state_ff == GNT1, state_ff == GNT0};

   // Flag goes up on the edge that brings the stall count to TIMEOUT_CYCLES-1.
   assign stall = (state_ff != IDLE) & o_wb_stb & ~i_wb_ack;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cnt_ff    <= '0;
         o_timeout <= 1'b0;
      end else begin
         if (!stall)             cnt_ff <= '0;
         else if (cnt_ff != '1)  cnt_ff <= cnt_ff + 1'b1;
         if (stall && cnt_ff == SET_AT) o_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// Directed bench for zap_wb_arbiter (TIMEOUT_CYCLES = 16, TIE_FIRST = 1).
module tb_zap_wb_arbiter;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        m0_cyc = 0, m0_stb = 0, m0_wen = 0;
   logic [3:0]  m0_sel = '0;
   logic [31:0] m0_dat = '0, m0_adr = '0;
   logic [2:0]  m0_cti = '0;
   logic        m1_cyc = 0, m1_stb = 0, m1_wen = 0;
   logic [3:0]  m1_sel = '0;
   logic [31:0] m1_dat = '0, m1_adr = '0;
   logic [2:0]  m1_cti = '0;
   logic [31:0] wb_rdat = '0;
   logic        wb_ack = 1'b0;
   logic [31:0] o_m0_dat, o_m1_dat, o_dat, o_adr;
   logic        o_m0_ack, o_m1_ack, o_cyc, o_stb, o_wen, o_timeout;
   logic [3:0]  o_sel;
   logic [2:0]  o_cti;
   logic [1:0]  o_gnt;

   int checks = 0;
   int failures = 0;

   zap_wb_arbiter #(.TIMEOUT_CYCLES(16), .TIE_FIRST(1)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_m0_wb_cyc(m0_cyc), .i_m0_wb_stb(m0_stb), .i_m0_wb_wen(m0_wen),
      .i_m0_wb_sel(m0_sel), .i_m0_wb_dat(m0_dat), .i_m0_wb_adr(m0_adr),
      .i_m0_wb_cti(m0_cti), .o_m0_wb_dat(o_m0_dat), .o_m0_wb_ack(o_m0_ack),
      .i_m1_wb_cyc(m1_cyc), .i_m1_wb_stb(m1_stb), .i_m1_wb_wen(m1_wen),
      .i_m1_wb_sel(m1_sel), .i_m1_wb_dat(m1_dat), .i_m1_wb_adr(m1_adr),
      .i_m1_wb_cti(m1_cti), .o_m1_wb_dat(o_m1_dat), .o_m1_wb_ack(o_m1_ack),
      .o_wb_cyc(o_cyc), .o_wb_stb(o_stb), .o_wb_wen(o_wen), .o_wb_sel(o_sel),
      .o_wb_dat(o_dat), .o_wb_adr(o_adr), .o_wb_cti(o_cti),
      .i_wb_dat(wb_rdat), .i_wb_ack(wb_ack), .o_gnt(o_gnt), .o_timeout(o_timeout)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      tick();
      checks++; if (o_gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", o_gnt); end
      checks++; if (o_cyc !== 1'b0 || o_stb !== 1'b0) begin failures++; $display("FAIL reset_cyc got=%b%b exp=00", o_cyc, o_stb); end
      checks++; if (o_adr !== 32'h0 || o_cti !== 3'b000 || o_sel !== 4'h0) begin failures++; $display("FAIL reset_bus adr=%h cti=%b sel=%h exp=0", o_adr, o_cti, o_sel); end
      checks++; if (o_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", o_timeout); end
      i_reset = 1'b0;
      #1;
   endtask

   task automatic test_single_m0();
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_1000; m0_sel = 4'hF; m0_dat = 32'h1111_2222;
      #1;
      checks++; if (o_cyc !== 1'b0) begin failures++; $display("FAIL single_latency cyc got=%b exp=0", o_cyc); end
      tick();
      checks++; if (o_gnt !== 2'b01) begin failures++; $display("FAIL single_gnt got=%b exp=01", o_gnt); end
      checks++; if (o_adr !== 32'h1000 || o_cyc !== 1'b1 || o_dat !== 32'h1111_2222) begin failures++; $display("FAIL single_bus adr=%h cyc=%b dat=%h exp=1000/1/11112222", o_adr, o_cyc, o_dat); end
      wb_ack = 1; wb_rdat = 32'hDEAD_BEEF;
      #1;
      checks++; if (o_m0_ack !== 1'b1 || o_m1_ack !== 1'b0) begin failures++; $display("FAIL single_ack got=%b%b exp=10", o_m0_ack, o_m1_ack); end
      checks++; if (o_m0_dat !== 32'hDEAD_BEEF || o_m1_dat !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_rdat got=%h/%h exp=deadbeef", o_m0_dat, o_m1_dat); end
      tick();
      wb_ack = 0; m0_cyc = 0; m0_stb = 0;
      #1;
      checks++; if (o_gnt !== 2'b01 || o_cyc !== 1'b0) begin failures++; $display("FAIL single_release gnt=%b cyc=%b exp=01/0", o_gnt, o_cyc); end
      tick();
      checks++; if (o_gnt !== 2'b00) begin failures++; $display("FAIL single_idle got=%b exp=00", o_gnt); end
      wb_ack = 1;
      #1;
      checks++; if (o_m0_ack !== 1'b0 || o_m1_ack !== 1'b0) begin failures++; $display("FAIL idle_ack got=%b%b exp=00", o_m0_ack, o_m1_ack); end
      tick();
      wb_ack = 0;
      checks++; if (o_gnt !== 2'b00) begin failures++; $display("FAIL idle_ack_state got=%b exp=00", o_gnt); end
   endtask

   task automatic test_tie();
      do_reset();
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h1000;
      m1_cyc = 1; m1_stb = 1; m1_adr = 32'h2000;
      tick();
      checks++; if (o_gnt !== 2'b10 || o_adr !== 32'h2000) begin failures++; $display("FAIL tie_first gnt=%b adr=%h exp=10/2000", o_gnt, o_adr); end
      m1_cyc = 0; m1_stb = 0;
      #1;
      checks++; if (o_gnt !== 2'b10 || o_cyc !== 1'b0) begin failures++; $display("FAIL tie_release gnt=%b cyc=%b exp=10/0", o_gnt, o_cyc); end
      tick();
      checks++; if (o_gnt !== 2'b01 || o_cyc !== 1'b1 || o_adr !== 32'h1000) begin failures++; $display("FAIL tie_handover gnt=%b cyc=%b adr=%h exp=01/1/1000", o_gnt, o_cyc, o_adr); end
      m0_cyc = 0; m0_stb = 0;
      tick();
      checks++; if (o_gnt !== 2'b00) begin failures++; $display("FAIL tie_idle got=%b exp=00", o_gnt); end
   endtask

   task automatic test_burst();
      logic [2:0] exp_cti;
      int acks1 = 0;
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h1000;
      m1_cyc = 1; m1_stb = 1; m1_adr = 32'h3000; m1_cti = 3'b010;
      tick();
      checks++; if (o_gnt !== 2'b10) begin failures++; $display("FAIL burst_gnt got=%b exp=10", o_gnt); end
      for (int i = 0; i < 8; i++) begin
         exp_cti = (i == 7) ? 3'b111 : 3'b010;
         m1_adr = 32'h3000 + 32'(4 * i); m1_cti = exp_cti; wb_ack = 1;
         #1;
         if (o_m1_ack === 1'b1 && o_m0_ack === 1'b0 && o_gnt === 2'b10 && o_cti === exp_cti && o_adr === m1_adr) acks1++;
         tick();
      end
      wb_ack = 0;
      checks++; if (acks1 != 8) begin failures++; $display("FAIL burst_acks got=%0d exp=8", acks1); end
      m1_cyc = 0; m1_stb = 0; m1_cti = 3'b000;
      #1;
      checks++; if (o_gnt !== 2'b10) begin failures++; $display("FAIL burst_hold got=%b exp=10", o_gnt); end
      tick();
      checks++; if (o_gnt !== 2'b01 || o_adr !== 32'h1000) begin failures++; $display("FAIL burst_next gnt=%b adr=%h exp=01/1000", o_gnt, o_adr); end
      m0_cyc = 0; m0_stb = 0;
      tick();
   endtask

   task automatic test_alternate();
      logic [1:0] exp_g;
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      tick();
      for (int t = 0; t < 4; t++) begin
         exp_g = (t % 2 == 0) ? 2'b10 : 2'b01;
         checks++; if (o_gnt !== exp_g) begin failures++; $display("FAIL alt_order t=%0d got=%b exp=%b", t, o_gnt, exp_g); end
         wb_ack = 1;
         #1;
         checks++; if ({o_m1_ack, o_m0_ack} !== exp_g) begin failures++; $display("FAIL alt_ack t=%0d got=%b exp=%b", t, {o_m1_ack, o_m0_ack}, exp_g); end
         tick();
         wb_ack = 0;
         if (exp_g[1]) begin m1_cyc = 0; m1_stb = 0; end else begin m0_cyc = 0; m0_stb = 0; end
         tick();
         m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      end
      m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
      tick();
      checks++; if (o_gnt !== 2'b00) begin failures++; $display("FAIL alt_idle got=%b exp=00", o_gnt); end
   endtask

   task automatic test_timeout();
      do_reset();
      m0_cyc = 1; m0_stb = 1;
      tick();
      repeat (14) tick();
      checks++; if (o_timeout !== 1'b0) begin failures++; $display("FAIL timeout_early got=%b exp=0", o_timeout); end
      tick();
      checks++; if (o_timeout !== 1'b1) begin failures++; $display("FAIL timeout_set got=%b exp=1", o_timeout); end
      wb_ack = 1;
      tick();
      wb_ack = 0; m0_cyc = 0; m0_stb = 0;
      tick(); tick();
      checks++; if (o_timeout !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b exp=1", o_timeout); end
      do_reset();
      checks++; if (o_timeout !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%b exp=0", o_timeout); end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      m0_cyc = 1; m0_stb = 1; m0_cti = 3'b010; m0_adr = 32'h4000;
      tick();
      checks++; if (o_gnt !== 2'b01) begin failures++; $display("FAIL midrst_gnt got=%b exp=01", o_gnt); end
      m1_cyc = 1; m1_stb = 1; m1_adr = 32'h5000; wb_ack = 1;
      tick();
      checks++; if (o_gnt !== 2'b01 || o_m0_ack !== 1'b1) begin failures++; $display("FAIL midrst_hold gnt=%b ack=%b exp=01/1", o_gnt, o_m0_ack); end
      i_reset = 1'b1;
      #1;
      checks++; if (o_cyc !== 1'b0 || o_gnt !== 2'b00) begin failures++; $display("FAIL midrst_async cyc=%b gnt=%b exp=0/00", o_cyc, o_gnt); end
      checks++; if (o_m0_ack !== 1'b0 || o_m1_ack !== 1'b0) begin failures++; $display("FAIL midrst_ack got=%b%b exp=00", o_m0_ack, o_m1_ack); end
      tick();
      i_reset = 1'b0; wb_ack = 0;
      #1;
      checks++; if (o_gnt !== 2'b00) begin failures++; $display("FAIL midrst_idle got=%b exp=00", o_gnt); end
      tick();
      checks++; if (o_gnt !== 2'b10 || o_adr !== 32'h5000) begin failures++; $display("FAIL midrst_tie gnt=%b adr=%h exp=10/5000", o_gnt, o_adr); end
      m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_m0();
      test_tie();
      test_burst();
      test_alternate();
      test_timeout();
      test_reset_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
